ps2_rx_decoder: RTL and testbench

PS/2 keyboard receive front end and scan-code filter. It samples the keyboard's ps2_clk/ps2_data lines and deframes 11-bit device-to-host frames. It strips break (F0) and extended (E0) prefixes and device status bytes, then writes one byte per key press into the 16-deep receive FIFO directly downstream. It drives that FIFO's wr/din ports and observes its full flag.

---
 rtl/ps2_rx_decoder_pkg.sv | 27 ++
 rtl/ps2_rx_decoder_if.sv | 9 +
 rtl/ps2_rx_decoder_in_filter.sv | 47 ++++
 rtl/ps2_rx_decoder.sv | 125 ++++++++++++
 tb/tb_ps2_rx_decoder.sv | 177 +++++++++++++++++
 5 files changed

// File: rtl/ps2_rx_decoder_pkg.sv
// Shared types and scan-code constants for the PS/2 receive decoder.
package ps2_rx_decoder_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_DECODE
  } state_t;

  localparam logic [7:0] SC_BREAK  = 8'hF0;
  localparam logic [7:0] SC_EXT    = 8'hE0;
  localparam logic [7:0] SC_BAT    = 8'hAA;
  localparam logic [7:0] SC_ACK    = 8'hFA;
  localparam logic [7:0] SC_ECHO   = 8'hEE;
  localparam logic [7:0] SC_RESEND = 8'hFE;
  localparam logic [7:0] SC_ERR0   = 8'h00;
  localparam logic [7:0] SC_ERR1   = 8'hFF;

  // Device status/response bytes that never represent a key.
  function automatic logic is_status(input logic [7:0] b);
    return (b == SC_BAT) || (b == SC_ACK) || (b == SC_ECHO) ||
           (b == SC_RESEND) || (b == SC_ERR0) || (b == SC_ERR1);
  endfunction

endpackage

// File: rtl/ps2_rx_decoder_if.sv
// Write side of the downstream receive FIFO.
interface ps2_rx_decoder_if;
  logic       wr;
  logic [7:0] dout;
  logic       fifo_full;

  modport master (output wr, output dout, input fifo_full);
  modport slave  (input wr, input dout, output fifo_full);
endinterface

// File: rtl/ps2_rx_decoder_in_filter.sv
// Synchronises both PS/2 lines, deglitches ps2_clk and emits a falling-edge pulse.
module ps2_in_filter #(
  parameter int FILT_LEN = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic ps2_clk,
  input  logic ps2_data,
  output logic fe,
  output logic data
);

  localparam int CW = $clog2(FILT_LEN + 1);

  logic [1:0]    clk_sync;
  logic [1:0]    data_sync;
  logic          filt;
  logic [CW-1:0] cnt;

  // NOTE: synchroniser and filter reset to 1 so an idle (high) bus gives no edge out of reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clk_sync  <= 2'b11;
      data_sync <= 2'b11;
      filt      <= 1'b1;
      cnt       <= '0;
      fe        <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register reading the pre-edge value.
      clk_sync  <= {clk_sync[0], ps2_clk};
      data_sync <= {data_sync[0], ps2_data};
      fe        <= 1'b0;
      if (clk_sync[1] == filt) begin
        cnt <= '0;
      end else if (cnt == CW'(FILT_LEN - 1)) begin
        filt <= clk_sync[1];
        cnt  <= '0;
        fe   <= filt;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign data = data_sync[1];

endmodule

// File: rtl/ps2_rx_decoder.sv
// PS/2 frame receiver and scan-code filter writing key-press codes into a FIFO.
module ps2_rx_decoder
  import ps2_rx_decoder_pkg::*;
#(
  parameter int FILT_LEN    = 8,
  parameter int TIMEOUT_CYC = 20000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ps2_clk,
  input  logic                     ps2_data,
  ps2_rx_decoder_if.master         fifo,
  output logic                     err,
  output logic                     overrun,
  input  logic                     clr_overrun,
  output logic                     busy
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  state_t        state, state_nx;
  logic          fe, data;
  logic [7:0]    shreg;
  logic [2:0]    bitcnt;
  logic          par_bit;
  logic [TW-1:0] tcnt;
  logic          brk, ext;
  logic          brk_nx, ext_nx, write_nx, err_nx, ovr_set;
  logic          timeout, frame_ok, in_frame;

  ps2_in_filter #(.FILT_LEN(FILT_LEN)) u_filt (
    .clk      (clk),
    .rst      (rst),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .fe       (fe),
    .data     (data)
  );

  assign in_frame = (state == ST_DATA) || (state == ST_PARITY) || (state == ST_STOP);
  assign timeout  = in_frame && !fe && (tcnt == TW'(TIMEOUT_CYC - 1));
  assign frame_ok = data && (^{shreg, par_bit});

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      shreg     <= '0;
      bitcnt    <= '0;
      par_bit   <= 1'b0;
      tcnt      <= '0;
      brk       <= 1'b0;
      ext       <= 1'b0;
      fifo.wr   <= 1'b0;
      fifo.dout <= 8'h00;
      err       <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      state   <= state_nx;
      brk     <= brk_nx;
      ext     <= ext_nx;
      fifo.wr <= write_nx;
      err     <= err_nx;
      if (write_nx) fifo.dout <= shreg;
      if (ovr_set) overrun <= 1'b1;
      else if (clr_overrun) overrun <= 1'b0;
      tcnt <= (in_frame && !fe) ? tcnt + 1'b1 : '0;
      if (fe) begin
        case (state)
          ST_IDLE:   bitcnt <= '0;
          ST_DATA: begin
            shreg  <= {data, shreg[7:1]};
            bitcnt <= bitcnt + 1'b1;
          end
          ST_PARITY: par_bit <= data;
          default:   ;
        endcase
      end
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:   if (fe && !data) state_nx = ST_DATA;
      ST_DATA:   if (timeout) state_nx = ST_IDLE;
                 else if (fe && bitcnt == 3'd7) state_nx = ST_PARITY;
      ST_PARITY: if (timeout) state_nx = ST_IDLE;
                 else if (fe) state_nx = ST_STOP;
      ST_STOP:   if (timeout) state_nx = ST_IDLE;
                 else if (fe) state_nx = frame_ok ? ST_DECODE : ST_IDLE;
      default:   state_nx = ST_IDLE;
    endcase
  end

  // NOTE: every output gets a default first so no path through the case infers a latch.
  always_comb begin
    brk_nx   = brk;
    ext_nx   = ext;
    write_nx = 1'b0;
    ovr_set  = 1'b0;
    busy     = (state != ST_IDLE);
    err_nx   = timeout || ((state == ST_STOP) && fe && !frame_ok);
    if (err_nx) begin
      brk_nx = 1'b0;
      ext_nx = 1'b0;
    end
    if (state == ST_DECODE) begin
      if (shreg == SC_BREAK) begin
        brk_nx = 1'b1;
      end else if (shreg == SC_EXT) begin
        ext_nx = 1'b1;
      end else if (is_status(shreg)) begin
        brk_nx = brk;
      end else if (brk) begin
        brk_nx = 1'b0;
        ext_nx = 1'b0;
      end else begin
        ext_nx = 1'b0;
        if (fifo.fifo_full) ovr_set = 1'b1;
        else write_nx = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ps2_rx_decoder.sv
// Scoreboard bench for ps2_rx_decoder: PS/2 frames in, FIFO writes checked against a queue.
module tb_ps2_rx_decoder;

  localparam int FILT      = 8;
  localparam int TMO       = 300;
  localparam int HALF_NS   = 400;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic ps2_clk = 1'b1;
  logic ps2_data = 1'b1;
  logic clr_overrun = 1'b0;
  logic err, overrun, busy;

  ps2_rx_decoder_if fif ();

  ps2_rx_decoder #(.FILT_LEN(FILT), .TIMEOUT_CYC(TMO)) dut (
    .clk         (clk),
    .rst         (rst),
    .ps2_clk     (ps2_clk),
    .ps2_data    (ps2_data),
    .fifo        (fif.master),
    .err         (err),
    .overrun     (overrun),
    .clr_overrun (clr_overrun),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] exp_q[$];
  int cyc = 0, fe_cyc = -100, fe_cnt = 0, wr_cnt = 0, err_cnt = 0;
  logic wr_prev = 1'b0, err_prev = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    cyc++;
    if (dut.fe) begin
      fe_cyc = cyc;
      fe_cnt++;
    end
    if (fif.wr) begin
      wr_cnt++;
      check("wr_single", {31'd0, wr_prev}, 0);
      check("wr_latency", cyc - fe_cyc, 2);
      check("wr_expected", {31'd0, exp_q.size() != 0}, 1);
      if (exp_q.size() != 0) check("dout", {24'd0, fif.dout}, {24'd0, exp_q.pop_front()});
    end
    if (err) begin
      err_cnt++;
      check("err_pulse", {31'd0, err_prev}, 0);
    end
    wr_prev  = fif.wr;
    err_prev = err;
  end

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input int nbits);
    logic [10:0] bits;
    bits = {1'b1, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2_data = bits[i];
      #(HALF_NS / 2);
      ps2_clk = 1'b0;
      #(HALF_NS);
      ps2_clk = 1'b1;
      #(HALF_NS / 2);
    end
    ps2_data = 1'b1;
  endtask

  task automatic key(input logic [7:0] b, input bit expect_wr);
    if (expect_wr) exp_q.push_back(b);
    send_frame(b, 1'b0, 11);
    repeat (60) @(posedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_wr"}, {31'd0, fif.wr}, 0);
    check({tag, "_dout"}, {24'd0, fif.dout}, 0);
    check({tag, "_err"}, {31'd0, err}, 0);
    check({tag, "_overrun"}, {31'd0, overrun}, 0);
    check({tag, "_busy"}, {31'd0, busy}, 0);
  endtask

  initial begin
    int e0, f0;
    fif.fifo_full = 1'b0;
    repeat (4) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b1;
    repeat (20) @(posedge clk);

    key(8'h1C, 1'b1);
    check("1c_written", wr_cnt, 1);
    check("1c_no_err", err_cnt, 0);

    key(8'hF0, 1'b0); key(8'h1C, 1'b0);
    key(8'hE0, 1'b0); key(8'h5A, 1'b1);
    key(8'hE0, 1'b0); key(8'hF0, 1'b0); key(8'h5A, 1'b0);
    check("seq_writes", wr_cnt, 2);
    check("seq_dout_hold", {24'd0, fif.dout}, 32'h5A);
    check("seq_flags", {30'd0, dut.brk, dut.ext}, 0);

    e0 = err_cnt;
    send_frame(8'h16, 1'b1, 11);
    repeat (60) @(posedge clk);
    check("par_err", err_cnt, e0 + 1);
    check("par_no_wr", wr_cnt, 2);
    key(8'h16, 1'b1);

    e0 = err_cnt;
    send_frame(8'h45, 1'b0, 5);
    @(negedge clk);
    check("tmo_busy_mid", {31'd0, busy}, 1);
    repeat (TMO + 50) @(posedge clk);
    @(negedge clk);
    check("tmo_err", err_cnt, e0 + 1);
    check("tmo_busy", {31'd0, busy}, 0);
    key(8'h45, 1'b1);

    fif.fifo_full = 1'b1;
    key(8'h29, 1'b0);
    check("full_overrun", {31'd0, overrun}, 1);
    repeat (100) @(posedge clk);
    check("full_sticky", {31'd0, overrun}, 1);
    fif.fifo_full = 1'b0;
    @(negedge clk) clr_overrun = 1'b1;
    @(negedge clk) clr_overrun = 1'b0;
    check("ovr_clear", {31'd0, overrun}, 0);
    key(8'hAA, 1'b0);
    check("status_no_wr", wr_cnt, 4);

    f0 = fe_cnt;
    e0 = err_cnt;
    @(negedge clk) ps2_clk = 1'b0;
    repeat (3) @(negedge clk);
    ps2_clk = 1'b1;
    repeat (30) @(negedge clk);
    check("glitch_no_fe", fe_cnt, f0);
    check("glitch_busy", {31'd0, busy}, 0);

    send_frame(8'h77, 1'b0, 5);
    @(negedge clk);
    check("mid_busy", {31'd0, busy}, 1);
    rst = 1'b0;
    #1;
    check_reset_outputs("midrst");
    check("midrst_state", {29'd0, dut.state}, 0);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    repeat (20) @(posedge clk);
    key(8'h32, 1'b1);
    check("glitch_no_err", err_cnt, e0);

    repeat (TMO + 50) @(posedge clk);
    check("final_writes", wr_cnt, 5);
    check("queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
